// File: rtl/safe_interval_timer.sv
// Prescaled countdown timer for the safe lock controller: one-shot or periodic,
// with pause/abort and a live count; abort > start > pause > tick.
module safe_interval_timer #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_LOAD = 10,
  parameter int PRESCALE     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             use_load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  // A one-bit prescaler is kept even for PRESCALE=1 so the vector never collapses.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] DEF_L   = WIDTH'(DEFAULT_LOAD);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic [WIDTH-1:0] load_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ps_q       <= '0;
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      expired_q  <= expired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    done_d     = done_q;
    expired_d  = 1'b0;
    load_sel   = use_load ? load_val : DEF_L;

    if (abort) begin
      state_d = IDLE;
      ps_d    = '0;
      count_d = '0;
      done_d  = 1'b0;
    end else if (start) begin
      reload_d   = load_sel;
      periodic_d = periodic;
      ps_d       = '0;
      if (load_sel == '0) begin
        // A zero load expires at once and is always treated as one-shot.
        state_d   = DONE;
        count_d   = '0;
        done_d    = 1'b1;
        expired_d = 1'b1;
      end else begin
        state_d = RUN;
        count_d = load_sel;
        done_d  = 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (!pause) begin
            if (ps_q == PS_LAST) begin
              ps_d = '0;
              if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
              end else if (periodic_q) begin
                count_d   = reload_q;
                expired_d = 1'b1;
              end else begin
                count_d   = '0;
                state_d   = DONE;
                done_d    = 1'b1;
                expired_d = 1'b1;
              end
            end else begin
              ps_d = ps_q + PW'(1);
            end
          end
        end
        DONE: begin
          count_d = '0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          ps_d    = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_safe_interval_timer.sv
// Directed bench: per-cycle vector table on a default instance, plus hand
// sequences for prescaled expiry, pause stretch and asynchronous reset.
module tb_safe_interval_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, use_load = 1'b0, periodic = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [7:0] load_val = '0;

  logic [7:0] count_a, count_b;
  logic       busy_a, done_a, expired_a;
  logic       busy_b, done_b, expired_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  safe_interval_timer #(.WIDTH(8), .DEFAULT_LOAD(10), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .use_load(use_load),
    .load_val(load_val), .periodic(periodic), .pause(pause), .abort(abort),
    .count(count_a), .busy(busy_a), .done(done_a), .expired(expired_a)
  );

  safe_interval_timer #(.WIDTH(8), .DEFAULT_LOAD(10), .PRESCALE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .use_load(use_load),
    .load_val(load_val), .periodic(periodic), .pause(pause), .abort(abort),
    .count(count_b), .busy(busy_b), .done(done_b), .expired(expired_b)
  );

  typedef struct {
    logic       start;
    logic       use_load;
    logic [7:0] load_val;
    logic       periodic;
    logic       pause;
    logic       abort;
    logic [7:0] exp_count;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_expired;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic ul, input logic [7:0] lv,
                                input logic per, input logic pa, input logic ab);
    @(negedge clk);
    start = s; use_load = ul; load_val = lv; periodic = per; pause = pa; abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] c, input logic b, input logic d, input logic e);
    check_output({tag, ".count"},   count_a, c);
    check_output({tag, ".busy"},    {7'd0, busy_a}, {7'd0, b});
    check_output({tag, ".done"},    {7'd0, done_a}, {7'd0, d});
    check_output({tag, ".expired"}, {7'd0, expired_a}, {7'd0, e});
  endtask

  function automatic vec_t mk(logic s, logic ul, logic [7:0] lv, logic per, logic pa, logic ab,
                              logic [7:0] c, logic b, logic d, logic e);
    vec_t v;
    v.start = s; v.use_load = ul; v.load_val = lv; v.periodic = per; v.pause = pa; v.abort = ab;
    v.exp_count = c; v.exp_busy = b; v.exp_done = d; v.exp_expired = e;
    return v;
  endfunction

  initial begin
    // Default one-shot: 10 down to 1, expiry on the tenth edge, then DONE holds.
    vecs.push_back(mk(1, 0, 8'd0, 0, 0, 0, 8'd10, 1, 0, 0));
    for (int k = 9; k >= 1; k--) vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'(k), 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 1, 0, 8'd0, 0, 1, 0));
    // Periodic load 2, then abort coinciding with an expiry tick.
    vecs.push_back(mk(1, 1, 8'd2, 1, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 8'd0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0));
    // Restart on the 1->0 tick, pause hold, then abort beats start.
    vecs.push_back(mk(1, 1, 8'd3, 0, 0, 0, 8'd3, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'd9, 0, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'd3, 0, 0, 0, 8'd3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 1, 0, 8'd3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 1, 0, 8'd3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'd5, 0, 0, 1, 8'd0, 0, 0, 0));
    // Zero load expires immediately even when periodic is requested.
    vecs.push_back(mk(1, 1, 8'd0, 1, 0, 0, 8'd0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 8'd6, 0, 0, 0, 8'd6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 8'd5, 1, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 8'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].start, vecs[i].use_load, vecs[i].load_val,
                     vecs[i].periodic, vecs[i].pause, vecs[i].abort);
      check_a($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy,
              vecs[i].exp_done, vecs[i].exp_expired);
    end

    // Asynchronous reset while counting at 5, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 8'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 1, 8'd7, 0, 0, 0);
      check_a($sformatf("post_rst%0d", k), 8'd0, 0, 0, 0);
    end

    // Prescale 4, load 3, one-shot: expiry on edge 12.
    apply_stimulus(1, 1, 8'd3, 0, 0, 0);
    check_output("ps4.start_count", count_b, 8'd3);
    for (int k = 1; k <= 13; k++) begin
      apply_stimulus(0, 0, 8'd0, 0, 0, 0);
      check_output($sformatf("ps4.count%0d", k), count_b, (k >= 12) ? 8'd0 : 8'(3 - k / 4));
      check_output($sformatf("ps4.expired%0d", k), {7'd0, expired_b}, (k == 12) ? 8'd1 : 8'd0);
      check_output($sformatf("ps4.done%0d", k), {7'd0, done_b}, (k >= 12) ? 8'd1 : 8'd0);
    end

    // Same run with pause held for five edges: expiry moves to edge 17.
    apply_stimulus(1, 1, 8'd3, 0, 0, 0);
    check_output("ps4p.restart_done", {7'd0, done_b}, 8'd0);
    for (int k = 1; k <= 18; k++) begin
      apply_stimulus(0, 0, 8'd0, 0, (k >= 5 && k <= 9), 0);
      check_output($sformatf("ps4p.expired%0d", k), {7'd0, expired_b}, (k == 17) ? 8'd1 : 8'd0);
      check_output($sformatf("ps4p.busy%0d", k), {7'd0, busy_b}, (k < 17) ? 8'd1 : 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/safe_interval_timer.md
# safe_interval_timer

Parametrised countdown timer for the safe lock controller: the general-purpose successor for entry timeouts, lockout penalties and periodic blink/retry ticks. It supports a runtime load value, a clock prescaler, one-shot or periodic mode, pause and abort, and exposes the live count. It sits beside the lock FSM, which starts it and consumes `done`/`expired`.

## Interface
- `WIDTH`, 8: count width in bits, ≥2.
- `DEFAULT_LOAD`, 10: reload value used when `use_load`=0; must fit in `WIDTH` bits.
- `PRESCALE`, 1: clock cycles per count decrement, ≥1.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: load and run, sampled each cycle.
- `use_load` in 1: at `start`, 1 selects `load_val`, 0 selects `DEFAULT_LOAD`.
- `load_val` in `WIDTH`: runtime reload value.
- `periodic` in 1: at `start`, 1 selects auto-reload mode.
- `pause` in 1: level; freezes count and prescaler while running.
- `abort` in 1: cancels the timer, returns to IDLE.
- `count` out `WIDTH`: current count value.
- `busy` out 1: high in RUN.
- `done` out 1: sticky expiry flag, one-shot mode only.
- `expired` out 1: one-cycle pulse on each expiry.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, `count`=0, prescaler=0, `busy`=0, `done`=0, `expired`=0.
- Priority, highest first: `abort` > `start` > `pause` > tick.
- `abort`, any state: → IDLE, `count`=0, prescaler=0, `done`=0. No `expired` pulse, even when it coincides with an expiry tick.
- `start`, any state: latch L (`load_val` or `DEFAULT_LOAD`) and the mode bit, `count`=L, prescaler=0, `done`=0, → RUN.
  - This restarts a running timer and suppresses any coincident expiry.
- `start` with L=0: → DONE immediately with `count`=0, `expired` pulses on that edge. Periodic is ignored; this always behaves as one-shot.
- RUN, `pause`=1: count and prescaler hold, `busy` stays 1.
- RUN, `pause`=0: the prescaler increments.
- Tick: the prescaler reaches `PRESCALE`-1. The prescaler wraps to 0 and:
  - `count`>1: `count` decrements by 1.
  - `count`=1, one-shot: `count`=0, → DONE, `expired`=1 for one cycle.
  - `count`=1, periodic: `count` reloads the latched L, stays in RUN, `expired`=1 for one cycle. `done` is never set.
- DONE: `count` holds 0 and `done` holds 1 until `start` or `abort`. `pause` has no effect.
- IDLE: `count`=0, all flags 0. `pause` and ticks are ignored.
- Arithmetic is unsigned and `count` never wraps below 0. `load_val` changes after `start` have no effect until the next `start`.

## Timing
- `start` sampled at edge E: `count`=L and `busy`=1 visible after E.
- One-shot expiry lands at edge E + L·`PRESCALE`. On that edge `count` becomes 0, `done` rises and `expired` pulses, all in the same cycle.
- Periodic mode: `expired` pulses every L·`PRESCALE` cycles, plus any cycles spent in pause.
- Each paused cycle delays expiry by exactly one cycle.
- `expired` is registered: high for exactly one cycle per expiry, never two consecutive cycles unless L·`PRESCALE`=1 in periodic mode.
- Asserting `rst_n` low mid-count forces all outputs to reset values asynchronously. Release resumes in IDLE.

## Test plan
- Defaults (W=8, L=10, P=1), `start` pulse at edge 0 → `count` 10, 9, …, 1, then 0 at edge 10 with `done`=1 and `expired` high for that cycle only; `done` stays 1.
- P=4, `use_load`=1, `load_val`=3, one-shot → expiry at edge 12. `pause` held for 5 cycles mid-run → expiry at edge 17.
- Periodic, `load_val`=2, P=1 → `expired` at edges 2, 4, 6…, `count` 2, 1, 2, 1…, `done` stays 0. `abort` at edge 7 → IDLE, `count`=0, no further pulses.
- `start` at the same edge as the 1→0 tick → `count` reloads to L, no `expired` pulse, `done` stays 0. `abort` and `start` together → IDLE.
- `load_val`=0 `start` → DONE next edge, `expired` single pulse, even with `periodic`=1.
- `rst_n` low during RUN with `count`=5 → `count`=0, `busy`/`done`/`expired`=0 immediately. After release, no activity until `start`.
